// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/FETCH/EXEC/HALTED sequencer that owns the PC and instruction register.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
    parameter int unsigned        ADDR_W   = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start_stop,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [ADDR_W+3:0] mem_data,
    output logic              w,
    output logic              x,
    output logic              y,
    output logic              z,
    output logic [ADDR_W-1:0] operand,
    output logic              instr_valid,
    input  logic              instr_done,
    input  logic              jump_en,
    input  logic              halt,
    output logic [ADDR_W-1:0] pc,
    output logic              fault
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic [ADDR_W+3:0]   ir_q;
    logic                mem_req_q;
    logic                instr_valid_q;

`ifdef FETCH_TIMEOUT_EN
    logic [3:0]          tmo_q;
    logic                fault_q;
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    // Halt outranks jump; the increment wraps naturally at the register width.
    always_comb begin
        pc_d = pc_q;
        if (state_q == FETCH && mem_ack) begin
            pc_d = pc_q + 1'b1;
        end else if (state_q == EXEC && instr_done && !halt && jump_en) begin
            pc_d = ir_q[ADDR_W-1:0];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            ir_q          <= '0;
            mem_req_q     <= 1'b0;
            instr_valid_q <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            tmo_q         <= '0;
            fault_q       <= 1'b0;
`endif
        end else begin
            pc_q <= pc_d;
            case (state_q)
                IDLE: begin
                    if (start_stop) begin
                        state_q   <= FETCH;
                        mem_req_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                        tmo_q     <= '0;
`endif
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        ir_q          <= mem_data;
                        state_q       <= EXEC;
                        mem_req_q     <= 1'b0;
                        instr_valid_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                    end else if (tmo_q == 4'd14) begin
                        // Fifteenth unanswered FETCH cycle: give up.
                        state_q   <= HALTED;
                        mem_req_q <= 1'b0;
                        fault_q   <= 1'b1;
                        tmo_q     <= 4'd15;
                    end else begin
                        tmo_q <= tmo_q + 4'd1;
`endif
                    end
                end
                EXEC: begin
                    if (instr_done) begin
                        instr_valid_q <= 1'b0;
                        if (halt) begin
                            state_q <= HALTED;
                        end else if (start_stop) begin
                            state_q   <= FETCH;
                            mem_req_q <= 1'b1;
`ifdef FETCH_TIMEOUT_EN
                            tmo_q     <= '0;
`endif
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                HALTED: begin
                    state_q <= HALTED;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = pc_q;
    assign pc          = pc_q;
    assign instr_valid = instr_valid_q;
    assign operand     = ir_q[ADDR_W-1:0];
    assign w           = ir_q[ADDR_W+3];
    assign x           = ir_q[ADDR_W+2];
    assign y           = ir_q[ADDR_W+1];
    assign z           = ir_q[ADDR_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit (ADDR_W=4, RESET_PC=0).
module tb_fetch_unit;

    logic       clock;
    logic       reset_n;
    logic       start_stop;
    logic       mem_req;
    logic [3:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_data;
    logic       w, x, y, z;
    logic [3:0] operand;
    logic       instr_valid;
    logic       instr_done;
    logic       jump_en;
    logic       halt;
    logic [3:0] pc;
    logic       fault;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    fetch_unit #(.ADDR_W(4), .RESET_PC(4'h0)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .start_stop  (start_stop),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .w           (w),
        .x           (x),
        .y           (y),
        .z           (z),
        .operand     (operand),
        .instr_valid (instr_valid),
        .instr_done  (instr_done),
        .jump_en     (jump_en),
        .halt        (halt),
        .pc          (pc),
        .fault       (fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; returns on the falling edge where outputs are sampled and inputs driven.
    task automatic tick(input int unsigned n = 1);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic ack(input logic [7:0] d);
        mem_data = d;
        mem_ack  = 1'b1;
        tick();
        mem_ack  = 1'b0;
        mem_data = 8'h00;
    endtask

    task automatic done(input logic j, input logic h);
        jump_en    = j;
        halt       = h;
        instr_done = 1'b1;
        tick();
        instr_done = 1'b0;
        jump_en    = 1'b0;
        halt       = 1'b0;
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        reset_n = 1'b1; start_stop = 1'b0; mem_ack = 1'b0; mem_data = 8'h00;
        instr_done = 1'b0; jump_en = 1'b0; halt = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_valid",   {31'd0, instr_valid}, 32'd0);
        check("rst_pc",      {28'd0, pc}, 32'h0);
        check("rst_fault",   {31'd0, fault}, 32'd0);
        check("rst_operand", {28'd0, operand}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        check("idle_no_req", {31'd0, mem_req}, 32'd0);

        // First fetch: 0x3A from address 0 after two wait cycles.
        start_stop = 1'b1;
        tick();
        check("f0_req",  {31'd0, mem_req}, 32'd1);
        check("f0_addr", {28'd0, mem_addr}, 32'h0);
        tick(2);
        check("f0_hold_req",  {31'd0, mem_req}, 32'd1);
        check("f0_hold_addr", {28'd0, mem_addr}, 32'h0);
        ack(8'h3A);
        check("e0_valid",   {31'd0, instr_valid}, 32'd1);
        check("e0_wxyz",    {28'd0, w, x, y, z}, 32'h3);
        check("e0_operand", {28'd0, operand}, 32'hA);
        check("e0_pc",      {28'd0, pc}, 32'h1);
        check("e0_no_req",  {31'd0, mem_req}, 32'd0);

        // mem_ack during EXEC must not touch IR or pc.
        ack(8'hC7);
        check("e0_ack_ign_op", {28'd0, operand}, 32'hA);
        check("e0_ack_ign_pc", {28'd0, pc}, 32'h1);

        done(1'b0, 1'b0);
        check("f1_req",   {31'd0, mem_req}, 32'd1);
        check("f1_addr",  {28'd0, mem_addr}, 32'h1);
        check("f1_valid", {31'd0, instr_valid}, 32'd0);
        ack(8'h75);
        check("e1_wxyz",    {28'd0, w, x, y, z}, 32'h7);
        check("e1_operand", {28'd0, operand}, 32'h5);
        check("e1_pc",      {28'd0, pc}, 32'h2);

        // Jump to operand 5.
        done(1'b1, 1'b0);
        check("jmp_req",  {31'd0, mem_req}, 32'd1);
        check("jmp_addr", {28'd0, mem_addr}, 32'h5);
        ack(8'h0F);
        check("e2_pc", {28'd0, pc}, 32'h6);
        done(1'b1, 1'b0);
        check("jmpF_addr", {28'd0, mem_addr}, 32'hF);
        ack(8'h12);
        check("wrap_pc",  {28'd0, pc}, 32'h0);
        check("wrap_op",  {28'd0, operand}, 32'h2);

        // Drop start_stop mid-EXEC: instruction completes, then IDLE.
        start_stop = 1'b0;
        tick(2);
        check("pause_valid", {31'd0, instr_valid}, 32'd1);
        done(1'b0, 1'b0);
        check("idle_req",   {31'd0, mem_req}, 32'd0);
        check("idle_valid", {31'd0, instr_valid}, 32'd0);
        ack(8'hFF);
        check("idle_ack_op", {28'd0, operand}, 32'h2);
        check("idle_ack_pc", {28'd0, pc}, 32'h0);
        check("idle_ack_req", {31'd0, mem_req}, 32'd0);
        start_stop = 1'b1;
        tick();
        check("resume_req",  {31'd0, mem_req}, 32'd1);
        check("resume_addr", {28'd0, mem_addr}, 32'h0);

        // instr_done during FETCH is ignored.
        done(1'b1, 1'b0);
        check("fetch_done_ign_req", {31'd0, mem_req}, 32'd1);
        check("fetch_done_ign_pc",  {28'd0, pc}, 32'h0);
        ack(8'h35);
        done(1'b0, 1'b0);
        check("pre_rst_addr", {28'd0, mem_addr}, 32'h1);

        // Asynchronous reset between edges mid-FETCH.
        start_stop = 1'b0;
        @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_req", {31'd0, mem_req}, 32'd0);
        check("arst_pc",  {28'd0, pc}, 32'h0);
        @(negedge clock);
        reset_n = 1'b1;
        ack(8'h99);
        check("late_ack_valid", {31'd0, instr_valid}, 32'd0);
        check("late_ack_op",    {28'd0, operand}, 32'h0);
        check("late_ack_pc",    {28'd0, pc}, 32'h0);

        // Halt with jump together: halt wins, pc unchanged.
        start_stop = 1'b1;
        tick();
        ack(8'h95);
        check("h_pc_before", {28'd0, pc}, 32'h1);
        done(1'b1, 1'b1);
        check("halt_req",   {31'd0, mem_req}, 32'd0);
        check("halt_valid", {31'd0, instr_valid}, 32'd0);
        check("halt_pc",    {28'd0, pc}, 32'h1);
        tick(3);
        ack(8'h44);
        check("halt_stay_req", {31'd0, mem_req}, 32'd0);
        check("halt_stay_pc",  {28'd0, pc}, 32'h1);
        check("halt_stay_op",  {28'd0, operand}, 32'h5);

        // Fetch with no acknowledge.
        do_reset();
        start_stop = 1'b1;
        tick();
        check("to_req_start", {31'd0, mem_req}, 32'd1);
`ifdef FETCH_TIMEOUT_EN
        tick(14);
        check("to_pre_fault", {31'd0, fault}, 32'd0);
        check("to_pre_req",   {31'd0, mem_req}, 32'd1);
        tick();
        check("to_fault",     {31'd0, fault}, 32'd1);
        check("to_req_off",   {31'd0, mem_req}, 32'd0);
        tick(5);
        check("to_halted",    {31'd0, mem_req}, 32'd0);
`else
        tick(100);
        check("no_to_req",   {31'd0, mem_req}, 32'd1);
        check("no_to_fault", {31'd0, fault}, 32'd0);
        check("no_to_addr",  {28'd0, mem_addr}, 32'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
